// File: rtl/mem_lsu_if.sv
// mem_lsu_if: pipeline request/response and data-memory signals of the load/store unit
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit with sub-word read-modify-write stores; LSU_BADADDR_EN adds badaddr_o
module mem_lsu #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  mem_lsu_if.slave    bus
`ifdef LSU_BADADDR_EN
  ,
  output logic [31:0] badaddr_o
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;
  state_t      state_q, state_d;
  logic        err_q, err_d, accept;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q, merged_q, load_d, merged_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  assign accept = bus.req_valid && bus.req_ready;
  // request legality evaluated on the raw inputs at acceptance
  assign err_d = (|bus.req_addr[31:ADDR_W])
              || (bus.req_we ? (bus.req_funct3[2] || bus.req_funct3[1:0] == 2'b11)
                             : !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
              || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
              || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
  assign lane_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
  // load extension: funct3[2] selects zero-extension, [1] word, [0] half
  assign load_d = f3_q[1] ? bus.mem_rdata
                : f3_q[0] ? {{16{lane_h[15] & ~f3_q[2]}}, lane_h}
                          : {{24{lane_b[7] & ~f3_q[2]}}, lane_b};
  // merge store data into the word just read, preserving the other lanes
  always_comb begin
    merged_d = bus.mem_rdata;
    if (f3_q[0]) merged_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else         merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // next state and memory/response outputs
  always_comb begin
    state_d        = state_q;
    bus.req_ready  = state_q == IDLE;
    bus.resp_valid = state_q == RESP;
    bus.resp_err   = state_q == RESP && err_q;
    bus.resp_rdata = rdata_q;
    bus.mem_read   = state_q == LOAD || state_q == RMW_RD;
    bus.mem_write  = !rst && (state_q == STORE || state_q == RMW_WR);
    bus.mem_addr   = {addr_q[31:2], 2'b00};
    bus.mem_wdata  = state_q == STORE ? wdata_q : state_q == RMW_WR ? merged_q : 32'h0;
    case (state_q)
      IDLE:    if (accept) state_d = err_d ? RESP : !bus.req_we ? LOAD
                                   : bus.req_funct3[1] ? STORE : RMW_RD;
      LOAD:    state_d = RESP;
      STORE:   state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  // request capture, load result and merged store word
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      merged_q <= 32'h0;
    end else begin
      if (accept) begin
        err_q   <= err_d;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= 32'h0;
      end
      if (state_q == LOAD)   rdata_q  <= load_d;
      if (state_q == RMW_RD) merged_q <= merged_d;
    end
  end
`ifdef LSU_BADADDR_EN
  // capture the faulting address as an errored request enters RESP
  always_ff @(posedge clk) begin
    if (rst)                 badaddr_o <= 32'h0;
    else if (accept && err_d) badaddr_o <= bus.req_addr;
  end
`endif
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu with a word-array memory model
module tb_mem_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_lsu_if bus();
`ifdef LSU_BADADDR_EN
  logic [31:0] badaddr;
`endif
  mem_lsu #(.ADDR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef LSU_BADADDR_EN
    ,
    .badaddr_o(badaddr)
`endif
  );
  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  int checks = 0;
  int failures = 0;
  int both = 0;
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end
  always @(negedge clk) if (bus.mem_read && bus.mem_write) both++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic er,
                     output int nr, output int nw, output int wc);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    #1 check("ready_idle", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    lat = 0; nr = 0; nw = 0; wc = 0; rd = 'x; er = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) bus.req_valid = 1'b0;
      nr += int'(bus.mem_read);
      if (bus.mem_write) begin nw++; wc = i; end
      if (bus.resp_valid) begin
        lat = i;
        rd = bus.resp_rdata;
        er = bus.resp_err;
        break;
      end
    end
    if (lat == 0) check("resp_timeout", 32'h0, 32'h1);
  endtask
  task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    int lat, nr, nw, wc;
    logic [31:0] rd;
    logic er;
    run(1'b0, f3, a, 32'h0, lat, rd, er, nr, nw, wc);
    check({tag, ".data"}, rd, exp);
    check({tag, ".lat"}, lat, 2);
    check({tag, ".err"}, {31'h0, er}, 32'h0);
  endtask
  task automatic bad(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a);
    int lat, nr, nw, wc;
    logic [31:0] rd;
    logic er;
    run(we, f3, a, 32'hFFFF_FFFF, lat, rd, er, nr, nw, wc);
    check({tag, ".lat"}, lat, 1);
    check({tag, ".err"}, {31'h0, er}, 32'h1);
    check({tag, ".memacc"}, nr + nw, 0);
    check({tag, ".data"}, rd, 32'h0);
  endtask
  initial begin
    int lat, nr, nw, wc;
    logic [31:0] rd;
    logic er;
    logic [7:0] rdy, rv;
    logic [31:0] d2, d5;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst.ctl", {27'h0, bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write}, 32'h10);
    check("rst.rdata", bus.resp_rdata, 32'h0);
    check("rst.addr", bus.mem_addr, 32'h0);
    check("rst.wdata", bus.mem_wdata, 32'h0);
`ifdef LSU_BADADDR_EN
    check("rst.badaddr", badaddr, 32'h0);
`endif
    rst = 1'b0;
    preload(6'd4, 32'h80FF7F01);
    preload(6'd8, 32'h11223344);
    preload(6'd9, 32'h55667788);
    preload(6'd63, 32'hCAFEF00D);
    ld("lb11", 3'b000, 32'h11, 32'h0000007F);
    ld("lb12", 3'b000, 32'h12, 32'hFFFFFFFF);
    ld("lbu13", 3'b100, 32'h13, 32'h00000080);
    ld("lh12", 3'b001, 32'h12, 32'hFFFF80FF);
    ld("lhu12", 3'b101, 32'h12, 32'h000080FF);
    ld("lw10", 3'b010, 32'h10, 32'h80FF7F01);
    ld("lw_last", 3'b010, 32'hFC, 32'hCAFEF00D);
    run(1'b1, 3'b000, 32'h22, 32'h000000AB, lat, rd, er, nr, nw, wc);
    check("sb.lat", lat, 3);
    check("sb.nwrites", nw, 1);
    check("sb.wcycle", wc, 2);
    check("sb.rdata", rd, 32'h0);
    check("sb.mem", mem[8], 32'h11AB3344);
    run(1'b1, 3'b001, 32'h20, 32'h0000BEEF, lat, rd, er, nr, nw, wc);
    check("sh.lat", lat, 3);
    check("sh.mem", mem[8], 32'h11ABBEEF);
    run(1'b1, 3'b010, 32'h30, 32'hDEADBEEF, lat, rd, er, nr, nw, wc);
    check("sw.lat", lat, 2);
    check("sw.wcycle", wc, 1);
    @(negedge clk);
    check("sw.mem", mem[12], 32'hDEADBEEF);
    bad("lh21", 1'b0, 3'b001, 32'h21);
    bad("sw22", 1'b1, 3'b010, 32'h22);
    bad("lw100", 1'b0, 3'b010, 32'h100);
`ifdef LSU_BADADDR_EN
    @(negedge clk);
    check("badaddr", badaddr, 32'h100);
`endif
    bad("ld_f3_011", 1'b0, 3'b011, 32'h10);
    bad("st_f3_100", 1'b1, 3'b100, 32'h20);
    check("err.mem8", mem[8], 32'h11ABBEEF);
    check("err.mem4", mem[4], 32'h80FF7F01);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h24;
    bus.req_wdata = 32'h99;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rmw.rd", {31'h0, bus.mem_read}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rmw.gated", {31'h0, bus.mem_write}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rmw.after", {30'h0, bus.req_ready, bus.resp_valid}, 32'h2);
    @(negedge clk);
    check("rmw.mem9", mem[9], 32'h55667788);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h10;
    @(posedge clk);
    rdy = '0; rv = '0; d2 = '0; d5 = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin bus.req_funct3 = 3'b100; bus.req_addr = 32'h13; end
      rdy[i-1] = bus.req_ready;
      rv[i-1] = bus.resp_valid;
      if (i == 2) d2 = bus.resp_rdata;
      if (i == 5) begin d5 = bus.resp_rdata; bus.req_valid = 1'b0; end
    end
    check("b2b.ready", {24'h0, rdy}, 32'hE4);
    check("b2b.valid", {24'h0, rv}, 32'h12);
    check("b2b.first", d2, 32'h80FF7F01);
    check("b2b.second", d5, 32'h00000080);
    check("rw_overlap", both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
